// File: rtl/trotrig_arm.sv
// Arming driver for a trotrig counting trigger: resets the target, streams beats, and checks the trigger
// against a plain shadow accumulator. Optional LFSR beat sequence via `TROTRIG_ARM_LFSR_EN.
module trotrig_arm #(
  parameter int                 DINBITS   = 8,
  parameter int                 COUNTBITS = 20,
  parameter logic [DINBITS-1:0] LFSR_TAPS = 'hB8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DINBITS-1:0]   fill,
  input  logic                 hold,
  input  logic                 trigger_in,
  output logic                 tgt_reset,
  output logic [DINBITS-1:0]   dout,
  output logic                 dout_en,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic                 miss,
  output logic                 early,
  output logic [COUNTBITS:0]   beats
);

`ifdef TROTRIG_ARM_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  // Two spare bits so the shadow sum can overshoot THRESH by a full step without wrapping.
  localparam int            AW     = DINBITS + COUNTBITS + 2;
  localparam logic [AW-1:0] THRESH = AW'(1) << (DINBITS + COUNTBITS);
  localparam logic [AW-1:0] BASE   = AW'(1) << DINBITS;

  typedef enum logic [1:0] {S_IDLE, S_TRST, S_STREAM, S_DONE} state_t;

  state_t             state;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_nxt;
  logic [DINBITS-1:0] fill_q;
  logic [DINBITS-1:0] seed;
  logic [DINBITS-1:0] next_d;
  logic               pred;

  assign acc_nxt = acc + AW'(dout) + BASE;
  assign pred    = acc_nxt > THRESH;
  assign dout_en = (state == S_STREAM) && !hold;

  // An all-zero LFSR state would lock up, so a zero fill seeds with 1.
  assign seed   = (LFSR_EN && fill_q == '0) ? {{(DINBITS-1){1'b0}}, 1'b1} : fill_q;
  assign next_d = LFSR_EN ? {dout[DINBITS-2:0], ^(dout & LFSR_TAPS)} : fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tgt_reset <= 1'b0;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      early     <= 1'b0;
      beats     <= '0;
      acc       <= '0;
      fill_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          fill_q    <= fill;
          hit       <= 1'b0;
          miss      <= 1'b0;
          early     <= 1'b0;
          beats     <= '0;
          acc       <= '0;
          dout      <= '0;
          tgt_reset <= 1'b1;
          busy      <= 1'b1;
          state     <= S_TRST;
        end
        S_TRST: begin
          tgt_reset <= 1'b0;
          dout      <= seed;
          state     <= S_STREAM;
        end
        S_STREAM: if (dout_en) begin
          beats <= beats + 1'b1;
          if (pred || trigger_in) begin
            hit   <= pred && trigger_in;
            miss  <= pred && !trigger_in;
            early <= !pred && trigger_in;
            done  <= 1'b1;
            dout  <= '0;
            state <= S_DONE;
          end else begin
            acc  <= acc_nxt;
            dout <= next_d;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trotrig_arm.sv
// Bench for trotrig_arm: behavioural target plus an arithmetic model of the expected beat sequence.
module tb_trotrig_arm;
  localparam int            DW   = 4;
  localparam int            CW   = 4;
  localparam logic [DW-1:0] TAPS = 4'h9;
`ifdef TROTRIG_ARM_LFSR_EN
  localparam bit LFSR = 1'b1;
`else
  localparam bit LFSR = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, hold = 1'b0, trigger_in;
  logic [DW-1:0] fill = '0, dout;
  logic          tgt_reset, dout_en, busy, done, hit, miss, early;
  logic [CW:0]   beats;

  int ntests = 0, nfail = 0;
  int tmode = 0, force_from = 0;
  int tacc = 0, tbcnt = 0;
  int exp_d[$];
  int exp_n = 0;

  always #5 clk = ~clk;

  trotrig_arm #(.DINBITS(DW), .COUNTBITS(CW), .LFSR_TAPS(TAPS)) dut (
    .clk(clk), .reset(reset), .start(start), .fill(fill), .hold(hold),
    .trigger_in(trigger_in), .tgt_reset(tgt_reset), .dout(dout), .dout_en(dout_en),
    .busy(busy), .done(done), .hit(hit), .miss(miss), .early(early), .beats(beats)
  );

  // Behavioural target: counts din+16 per enabled beat, fires combinationally past 256.
  always @(posedge clk) begin
    if (tgt_reset) begin
      tacc  <= 0;
      tbcnt <= 0;
    end else if (dout_en) begin
      tacc  <= tacc + int'(dout) + 16;
      tbcnt <= tbcnt + 1;
    end
  end

  always_comb begin
    case (tmode)
      1:       trigger_in = 1'b0;
      2:       trigger_in = (tbcnt + 1 >= force_from);
      default: trigger_in = dout_en && (tacc + int'(dout) + 16 > 256);
    endcase
  end

  task automatic chk(input string tag, input longint obs, input longint want);
    ntests++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Expected beat values and firing beat index for a given fill.
  task automatic model(input int f);
    int a;
    int d;
    a = 0;
    d = (LFSR && f == 0) ? 1 : f;
    exp_d.delete();
    exp_n = -1;
    for (int k = 1; k <= 40; k++) begin
      exp_d.push_back(d);
      a += d + 16;
      if (a > 256) begin
        exp_n = k;
        return;
      end
      if (LFSR) d = ((d << 1) & 15) | ($countones(d & int'(TAPS)) & 1);
    end
  endtask

  task automatic run(input string tag, input int f, input int mode, input int ff,
                     input int hold_pct, input int hold_from, input int rst_at);
    int nb, ndone, ntrst, hcnt, eb;
    bit fin, hwin, did_rst;
    logic [2:0] eflags;
    nb = 0; ndone = 0; ntrst = 0; hcnt = 0; fin = 0; did_rst = 0;
    model(f);
    eb = exp_n;
    if (mode == 1)                     eflags = 3'b010;
    else if (mode == 2 && ff < exp_n) begin eflags = 3'b001; eb = ff; end
    else                               eflags = 3'b100;

    fill = DW'(f); tmode = mode; force_from = ff; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold  = (hold_pct > 0);
    #1;
    chk({tag, ".trst"}, {tgt_reset, dout_en, busy, dout}, 7'b1010000);

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      hwin = hold_from > 0 && nb >= hold_from && hcnt < 5;
      if (hwin) hcnt++;
      hold  = hwin || ($urandom_range(99) < hold_pct);
      start = ($urandom_range(7) == 0);
      #1;
      if (tgt_reset) ntrst++;
      if (done) begin
        ndone++;
        fin = 1;
        chk({tag, ".done_en"}, {dout_en, busy}, 2'b01);
      end else begin
        chk({tag, ".en"}, dout_en, !hold);
        if (dout_en) begin
          chk($sformatf("%s.dout%0d", tag, nb), dout, nb < exp_d.size() ? exp_d[nb] : -1);
          nb++;
          if (rst_at > 0 && nb == rst_at) begin
            reset = 1'b1; start = 1'b1; fin = 1; did_rst = 1;
          end
        end
      end
    end
    chk({tag, ".finished"}, fin, 1);

    if (did_rst) begin
      @(negedge clk);
      #1;
      chk({tag, ".rst_idle"}, {tgt_reset, dout, dout_en, busy, done, hit, miss, early, beats}, 0);
      reset = 1'b0; start = 1'b0; hold = 1'b0;
      return;
    end

    chk({tag, ".trst_once"}, ntrst, 0);
    chk({tag, ".flags"}, {hit, miss, early}, eflags);
    chk({tag, ".beats"}, beats, eb);
    chk({tag, ".nbeats"}, nb, eb);
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
    #1;
    chk({tag, ".idle"}, {done, busy, hit, miss, early}, {2'b00, eflags});
    chk({tag, ".beats_hold"}, beats, eb);
  endtask

  initial begin
    int f, m, ff;
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", {tgt_reset, dout, dout_en, busy, done, hit, miss, early, beats}, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    run("s1_fill15",   15, 0, 0, 0, 0, 0);
    run("s2_fill0",     0, 0, 0, 0, 0, 0);
    run("s3_miss",     15, 1, 0, 0, 0, 0);
    run("s4_early",    15, 2, 3, 0, 0, 0);
    run("s5_hold",     15, 0, 0, 0, 3, 0);
    run("s6_rst",      15, 0, 0, 0, 0, 4);
    run("s6_rerun",    15, 0, 0, 0, 0, 0);
    run("s7_seed0",     0, 0, 0, 0, 0, 0);
    run("edge_fire1",  15, 2, 1, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      f = int'($urandom_range(15));
      m = int'($urandom_range(2));
      model(f);
      ff = int'($urandom_range(exp_n, 1));
      run($sformatf("rnd%0d", i), f, m, ff, int'($urandom_range(40)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
